// File: rtl/ap_drv_pkg.sv
// Shared types and helpers for the ap_ctrl_hs initiator: FSM state, default widths,
// saturating increment.
package ap_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    DONE
  } state_t;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_LAT_W = 32;

  // Callers pass their all-ones value as limit; widths up to 32 bits are supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ap_drv_lat_tracker.sv
// Per-transaction latency counter with last/max capture. A transaction's latency counts
// its first ap_start-high cycle through its ap_done cycle, inclusive.
module ap_drv_lat_tracker
  import ap_drv_pkg::*;
#(
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start_edge,
  input  logic             done_pulse,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat
);

  localparam logic [31:0] LAT_MAX = 32'({LAT_W{1'b1}});

  logic [LAT_W-1:0] count;
  logic [LAT_W-1:0] cur;

  // The start cycle itself counts as 1, so a same-cycle done reports latency 1.
  always_comb begin
    cur = start_edge ? LAT_W'(1) : LAT_W'(sat_inc(32'(count), LAT_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      last_lat <= '0;
      max_lat  <= '0;
    end else begin
      count <= cur;
      if (clear) begin
        last_lat <= '0;
        max_lat  <= '0;
      end else if (done_pulse) begin
        last_lat <= cur;
        if (cur > max_lat) max_lat <= cur;
      end
    end
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: issues a programmed number of ap_start transactions and counts
// ready/done handshakes. Define AP_DRV_LATENCY_EN to build the latency tracker.
module ap_ctrl_hs_driver
  import ap_drv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT_W = DEF_LAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_go,
  input  logic [CNT_W-1:0] cfg_num_trans,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] started_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic             proto_err,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  state_t           state, next_state;
  logic [CNT_W-1:0] num_trans;
  logic [CNT_W-1:0] done_next;
  logic             accept;
  logic             ready_hs;
  logic             done_pulse;
  logic             violation;

  assign accept     = cmd_go && (state == IDLE || state == DONE);
  assign ready_hs   = (state == ISSUE) && ap_ready;
  assign done_pulse = (ready_hs && ap_done) || (state == WAIT_DONE && ap_done);
  assign done_next  = CNT_W'(sat_inc(32'(done_cnt), CNT_MAX));
  assign violation  = (ap_done && (state == IDLE || state == DONE))
                   || (state == ISSUE && ap_done && !ap_ready)
                   || (state == WAIT_DONE && ap_ready);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state defaults to state before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (cmd_go) next_state = (cfg_num_trans == '0) ? DONE : ISSUE;
      ISSUE: begin
        if (ap_ready) begin
          if (ap_done) next_state = (done_next < num_trans) ? ISSUE : DONE;
          else         next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: if (ap_done) next_state = (done_next < num_trans) ? ISSUE : DONE;
      default:   next_state = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register, so ap_start is glitch-free.
  always_comb begin
    ap_start = (state == ISSUE);
    busy     = (state == ISSUE) || (state == WAIT_DONE);
    finish   = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      num_trans   <= '0;
      started_cnt <= '0;
      done_cnt    <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (accept) begin
        num_trans   <= cfg_num_trans;
        started_cnt <= '0;
        done_cnt    <= '0;
      end else begin
        if (ready_hs)   started_cnt <= CNT_W'(sat_inc(32'(started_cnt), CNT_MAX));
        if (done_pulse) done_cnt    <= done_next;
      end
      // A violation in the same cycle as the restart still leaves the flag set.
      proto_err <= (proto_err && !accept) || violation;
    end
  end

`ifdef AP_DRV_LATENCY_EN
  logic start_edge;

  // Fresh entry into ISSUE opens a transaction; ISSUE still waiting on ap_ready does not.
  always_ff @(posedge clock) begin
    if (reset) start_edge <= 1'b0;
    else       start_edge <= (next_state == ISSUE) && !(state == ISSUE && !ap_ready);
  end

  ap_drv_lat_tracker #(.LAT_W(LAT_W)) u_lat (
    .clock      (clock),
    .reset      (reset),
    .clear      (accept),
    .start_edge (start_edge),
    .done_pulse (done_pulse),
    .last_lat   (last_lat),
    .max_lat    (max_lat)
  );
`else
  assign last_lat = '0;
  assign max_lat  = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Randomized bench for ap_ctrl_hs_driver: a scripted core follows a per-transaction
// schedule and expected outputs are derived from that schedule.
`timescale 1ns/1ps
module tb_ap_ctrl_hs_driver;

  localparam int CNT_W   = 16;
  localparam int LAT_W   = 6;
  localparam int LAT_SAT = (1 << LAT_W) - 1;
`ifdef AP_DRV_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, cmd_go, ap_ready, ap_done;
  logic [CNT_W-1:0] cfg_num_trans;
  logic             ap_start, busy, finish, proto_err;
  logic [CNT_W-1:0] started_cnt, done_cnt;
  logic [LAT_W-1:0] last_lat, max_lat;

  int n_vec = 0;
  int n_err = 0;

  // Per-transaction schedule: cycles of ap_start before ap_ready, then cycles until ap_done.
  int r_q[$];
  int d_q[$];

  always #5 clock = ~clock;

  ap_ctrl_hs_driver #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_go        (cmd_go),
    .cfg_num_trans (cfg_num_trans),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .busy          (busy),
    .finish        (finish),
    .started_cnt   (started_cnt),
    .done_cnt      (done_cnt),
    .proto_err     (proto_err),
    .last_lat      (last_lat),
    .max_lat       (max_lat)
  );

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx, input bit st, input bit bz, input bit fin,
                               input int sc, input int dc, input bit pe, input int ll, input int ml);
    expect_eq({ctx, " ap_start"},    64'(ap_start),    64'(st));
    expect_eq({ctx, " busy"},        64'(busy),        64'(bz));
    expect_eq({ctx, " finish"},      64'(finish),      64'(fin));
    expect_eq({ctx, " started_cnt"}, 64'(started_cnt), 64'(sc));
    expect_eq({ctx, " done_cnt"},    64'(done_cnt),    64'(dc));
    expect_eq({ctx, " proto_err"},   64'(proto_err),   64'(pe));
    expect_eq({ctx, " last_lat"},    64'(last_lat),    LAT_EN ? 64'(ll) : 64'd0);
    expect_eq({ctx, " max_lat"},     64'(max_lat),     LAT_EN ? 64'(ml) : 64'd0);
  endtask

  function automatic int txn_len(input int i);
    return r_q[i] + 1 + d_q[i];
  endfunction

  function automatic int lat_of(input int i);
    return (txn_len(i) > LAT_SAT) ? LAT_SAT : txn_len(i);
  endfunction

  task automatic drive_idle();
    cmd_go = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; cfg_num_trans = '0;
  endtask

  task automatic push_txn(input int r, input int d);
    r_q.push_back(r);
    d_q.push_back(d);
  endtask

  // One run of n transactions from IDLE or DONE. inj_done0 raises ap_done alongside cmd_go;
  // abort_c > 0 asserts reset in that run cycle and ends the run.
  task automatic run(input string ctx, input int n, input bit inj_done0, input int abort_c);
    int total, i, o, ll, ml;
    total = 0;
    for (int k = 0; k < n; k++) total += txn_len(k);

    @(posedge clock); #1;
    cmd_go = 1'b1; cfg_num_trans = CNT_W'(n); ap_ready = 1'b0; ap_done = inj_done0;

    for (int c = 1; c <= total; c++) begin
      @(posedge clock); #1;
      i = 0; o = c - 1;
      while (o >= txn_len(i)) begin
        o -= txn_len(i);
        i++;
      end
      ap_ready      = (o == r_q[i]);
      ap_done       = (o == r_q[i] + d_q[i]);
      cmd_go        = ($urandom_range(0, 3) == 0);
      cfg_num_trans = CNT_W'($urandom);
      reset         = (c == abort_c);
      ll = 0; ml = 0;
      for (int k = 0; k < i; k++) begin
        ll = lat_of(k);
        if (ll > ml) ml = ll;
      end
      @(negedge clock);
      check_outputs(ctx, o <= r_q[i], 1'b1, 1'b0, i + ((o > r_q[i]) ? 1 : 0), i, inj_done0, ll, ml);
      if (c == abort_c) begin
        @(posedge clock); #1;
        reset = 1'b0;
        drive_idle();
        @(negedge clock);
        check_outputs({ctx, " post-reset"}, 0, 0, 0, 0, 0, 0, 0, 0);
        return;
      end
    end

    @(posedge clock); #1;
    drive_idle();
    ll = 0; ml = 0;
    for (int k = 0; k < n; k++) begin
      ll = lat_of(k);
      if (ll > ml) ml = ll;
    end
    @(negedge clock);
    check_outputs({ctx, " end"}, 0, 0, 1, n, n, inj_done0, ll, ml);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock); #1;
      @(negedge clock);
      check_outputs({ctx, " hold"}, 0, 0, 1, n, n, inj_done0, ll, ml);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // ap_done while IDLE, then a run started together with another stray ap_done.
    @(posedge clock); #1;
    ap_done = 1'b1;
    @(posedge clock); #1;
    ap_done = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check_outputs("idle_done", 0, 0, 0, 0, 0, 1, 0, 0);
      @(posedge clock); #1;
    end
    r_q.delete(); d_q.delete();
    push_txn(1, 2);
    run("proto_run", 1, 1'b1, 0);

    // Combinational core: ready = done = ap_start.
    r_q.delete(); d_q.delete();
    for (int k = 0; k < 5; k++) push_txn(0, 0);
    run("comb5", 5, 1'b0, 0);

    // ap_done while DONE flags a violation; finish stays high.
    @(posedge clock); #1;
    ap_done = 1'b1;
    @(posedge clock); #1;
    ap_done = 1'b0;
    @(negedge clock);
    check_outputs("done_done", 0, 0, 1, 5, 5, 1, 1, 1);

    r_q.delete(); d_q.delete();
    push_txn(0, 3); push_txn(0, 3);
    run("delay3", 2, 1'b0, 0);

    r_q.delete(); d_q.delete();
    run("zero", 0, 1'b0, 0);

    // Long first transaction saturates the latency registers.
    r_q.delete(); d_q.delete();
    push_txn(30, 40); push_txn(0, 0);
    run("lat_sat", 2, 1'b0, 0);

    // Reset while in WAIT_DONE, then a normal run from IDLE.
    r_q.delete(); d_q.delete();
    for (int k = 0; k < 4; k++) push_txn(0, 3);
    run("abort", 4, 1'b0, 2);
    r_q.delete(); d_q.delete();
    push_txn(2, 1); push_txn(0, 0); push_txn(1, 4);
    run("after_abort", 3, 1'b0, 0);

    for (int t = 0; t < 25; t++) begin
      r_q.delete(); d_q.delete();
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) push_txn($urandom_range(0, 3), $urandom_range(0, 4));
      run("rand", n, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_hs_driver.md
# ap_ctrl_hs_driver

Synthesizable initiator for the ap_ctrl_hs block-level handshake: drives ap_start into an HLS core and consumes its ap_ready/ap_done, issuing a programmed number of back-to-back transactions. Sits between bench/system control and the core under test. Produces the level `finish` consumed by the dataflow monitors. Optionally measures per-transaction latency.

## Interface
- CNT_W, 16, width of transaction count and counters
- LAT_W, 32, width of latency registers
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_go  in  1  single-cycle request to start a run; sampled only in IDLE or DONE
- cfg_num_trans  in  CNT_W  transactions per run; captured on accepted cmd_go
- ap_start  out  1  registered start to core
- ap_ready  in  1  core accepted inputs
- ap_done  in  1  core produced result
- busy  out  1  high in ISSUE or WAIT_DONE
- finish  out  1  high in DONE
- started_cnt  out  CNT_W  ap_ready handshakes this run
- done_cnt  out  CNT_W  ap_done pulses this run
- proto_err  out  1  sticky protocol-violation flag
- last_lat  out  LAT_W  latency of most recent transaction
- max_lat  out  LAT_W  maximum latency this run

## Operation
- Reset values: ap_start 0, busy 0, finish 0, counters 0, proto_err 0, last_lat 0, max_lat 0; state IDLE.
- IDLE: cmd_go -> capture cfg_num_trans, clear counters, proto_err, latencies; go ISSUE, or go DONE if cfg_num_trans == 0.
- ISSUE: ap_start = 1. Stay until ap_ready.
  - On ap_ready: started_cnt++.
  - If ap_done in the same cycle: done_cnt++, record latency. Go ISSUE if done_cnt+1 < N, else DONE. Combinational cores qualify.
  - Otherwise go WAIT_DONE.
- WAIT_DONE: ap_start = 0.
  - On ap_done: done_cnt++, record latency. Go ISSUE if more remain, else DONE.
- DONE: finish held high. cmd_go restarts exactly as from IDLE.
- Protocol violations set proto_err; the FSM stays on its normal path:
  - ap_done in IDLE or DONE.
  - ap_done in ISSUE without ap_ready.
  - ap_ready in WAIT_DONE.
- cmd_go in ISSUE or WAIT_DONE: ignored.
- Counters saturate at all-ones; no wrap.

## Timing
- ap_start rises the cycle after the accepted cmd_go.
- ap_start stays high continuously across back-to-back same-cycle ready/done transactions.
- Latency counts cycles from the first ap_start-high cycle of a transaction through its ap_done cycle, inclusive:
  - Combinational core: 1.
  - Done 3 cycles after start: 4.
  - Latency saturates at all-ones.
- finish rises the cycle after the final ap_done; for N = 0, the cycle after cmd_go.
- Reset mid-run: on the next edge ap_start = 0 and all outputs return to reset values. No transaction is completed.

## Configuration
- AP_DRV_LATENCY_EN
  - Defined: latency counter, last_lat and max_lat implemented as above.
  - Undefined: no latency logic is instantiated; last_lat and max_lat are tied to 0. Handshake behaviour is identical.

## Structure
- Package ap_drv_pkg:
  - State enum: IDLE, ISSUE, WAIT_DONE, DONE.
  - Default CNT_W and LAT_W constants.
  - Saturating-increment function.
- Sub-module ap_drv_lat_tracker holds the latency counter and the last/max registers.
  - Instantiated only under AP_DRV_LATENCY_EN.
  - Inputs: clock, reset, clear, start_edge, done_pulse.

## Test plan
- Combinational core (ready = done = ap_start), N=5: ap_start high 5 consecutive cycles; finish the next cycle; started_cnt = done_cnt = 5; last_lat = max_lat = 1.
- Core with ready immediately and done 3 cycles later, N=2: ap_start pulses 1 cycle per transaction; last_lat = 4; finish after second done.
- N=0: finish 1 cycle after cmd_go; ap_start never asserted; counters 0.
- ap_done injected in IDLE, then a run of N=1: proto_err = 1 and remains set.
- Reset asserted in WAIT_DONE with N=4: next cycle all outputs 0, state IDLE; a following cmd_go runs normally.
- Build without AP_DRV_LATENCY_EN, N=3 with a variable-latency core: handshake and counts identical to the enabled build; last_lat = max_lat = 0.
